// File: rtl/sad_trigger_stream_if.sv
// FIFO-side bundle of the SAD engine: reference and sample FWFT read ports plus the result write port.
// master = the engine (drives read/write strobes), slave = the FIFOs around it.
interface sad_trigger_stream_if #(
  parameter int DATA_WIDTH = 10,
  parameter int SUM_WIDTH  = 20
);
  logic [DATA_WIDTH-1:0] ref_points_in_V_dout;
  logic                  ref_points_in_V_empty_n;
  logic                  ref_points_in_V_read;
  logic [DATA_WIDTH-1:0] datain_V_dout;
  logic                  datain_V_empty_n;
  logic                  datain_V_read;
  logic [SUM_WIDTH-1:0]  sumout_V_din;
  logic                  sumout_V_full_n;
  logic                  sumout_V_write;

  modport master (
    input  ref_points_in_V_dout, ref_points_in_V_empty_n,
    input  datain_V_dout, datain_V_empty_n, sumout_V_full_n,
    output ref_points_in_V_read, datain_V_read, sumout_V_din, sumout_V_write
  );

  modport slave (
    output ref_points_in_V_dout, ref_points_in_V_empty_n,
    output datain_V_dout, datain_V_empty_n, sumout_V_full_n,
    input  ref_points_in_V_read, datain_V_read, sumout_V_din, sumout_V_write
  );
endinterface

// File: rtl/sad_trigger_stream.sv
// Streaming SAD engine: loads an N-point reference, slides it over the sample stream and emits one
// saturated SAD per full window, with a threshold trigger pulse that is gated by a holdoff counter.
module sad_trigger_stream #(
  parameter int DATA_WIDTH = 10,
  parameter int MAX_POINTS = 128,
  parameter int CNT_WIDTH  = 8,
  parameter int SUM_WIDTH  = 20,
  parameter int HOLD_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  input  logic                  ap_stop,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [CNT_WIDTH-1:0]  max_points_V,
  input  logic [SUM_WIDTH-1:0]  threshold_V,
  input  logic [HOLD_WIDTH-1:0] holdoff_V,
  sad_trigger_stream_if.master  fifo,
  output logic                  trig_out
);

  localparam int TERM_W = DATA_WIDTH + 1;
  localparam int ACC_W  = TERM_W + $clog2(MAX_POINTS) + 1;
  localparam int TOT_W  = (SUM_WIDTH > ACC_W) ? SUM_WIDTH : ACC_W;
  localparam logic [TOT_W-1:0]     SAT_MAX = (TOT_W'(1) << SUM_WIDTH) - TOT_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    n_q, n_d;
  logic [CNT_WIDTH-1:0]    ld_cnt_q, ld_cnt_d;
  logic [CNT_WIDTH-1:0]    fill_q, fill_d;
  logic                    out_valid_q, out_valid_d;
  logic [SUM_WIDTH-1:0]    sum_q, sum_d;
  logic                    trig_q, trig_d;
  logic [HOLD_WIDTH-1:0]   hold_q, hold_d;
  logic                    ready_q, ready_d;
  logic                    stop_q, stop_d;

  logic                    ref_we;
  logic                    ref_rd;
  logic                    data_rd;
  logic [CNT_WIDTH-1:0]    n_eff;
  logic [CNT_WIDTH-1:0]    n_last;
  logic [CNT_WIDTH-1:0]    ref_waddr;
  logic [TOT_W-1:0]        total;
  logic [SUM_WIDTH-1:0]    sad_sat;

  // Reference is stored reversed and the window newest-first, so tap j always pairs win[j] with ref[N-1-j].
  logic signed [DATA_WIDTH-1:0] ref_q [MAX_POINTS];
  logic signed [DATA_WIDTH-1:0] win_q [MAX_POINTS];
  logic signed [DATA_WIDTH-1:0] win_d [MAX_POINTS];
  logic        [TERM_W-1:0]     term  [MAX_POINTS];

  assign n_eff     = (max_points_V > CNT_WIDTH'(MAX_POINTS)) ? CNT_WIDTH'(MAX_POINTS) : max_points_V;
  assign n_last    = n_q - CNT_ONE;
  assign ref_waddr = n_last - ld_cnt_q;

  for (genvar gi = 0; gi < MAX_POINTS; gi++) begin : g_tap
    logic signed [DATA_WIDTH:0] diff;
    if (gi == 0) begin : g_head
      assign win_d[gi] = $signed(fifo.datain_V_dout);
    end else begin : g_body
      assign win_d[gi] = win_q[gi-1];
    end
    assign diff     = $signed({win_d[gi][DATA_WIDTH-1], win_d[gi]}) - $signed({ref_q[gi][DATA_WIDTH-1], ref_q[gi]});
    assign term[gi] = (n_q > CNT_WIDTH'(gi)) ? (diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff)) : '0;
  end

  always_comb begin
    total = '0;
    for (int j = 0; j < MAX_POINTS; j++) begin
      total = total + TOT_W'(term[j]);
    end
  end

  assign sad_sat = (total > SAT_MAX) ? {SUM_WIDTH{1'b1}} : total[SUM_WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    ld_cnt_d    = ld_cnt_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q && !fifo.sumout_V_full_n;
    sum_d       = sum_q;
    trig_d      = 1'b0;
    hold_d      = hold_q;
    ready_d     = 1'b0;
    stop_d      = stop_q;
    ref_we      = 1'b0;
    ref_rd      = 1'b0;
    data_rd     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          n_d      = n_eff;
          ld_cnt_d = '0;
          fill_d   = '0;
          stop_d   = 1'b0;
          state_d  = (n_eff == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        ref_rd = fifo.ref_points_in_V_empty_n;
        if (fifo.ref_points_in_V_empty_n) begin
          ref_we   = 1'b1;
          ld_cnt_d = ld_cnt_q + CNT_ONE;
          if (ld_cnt_q == n_last) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (ap_stop) stop_d = 1'b1;
        data_rd = fifo.datain_V_empty_n && (!out_valid_q || fifo.sumout_V_full_n) && !(stop_q || ap_stop);
        if (data_rd) begin
          if (hold_q != '0) hold_d = hold_q - HOLD_WIDTH'(1);
          if (fill_q == n_last) begin
            out_valid_d = 1'b1;
            sum_d       = sad_sat;
            // A trigger reloads the holdoff, overriding this sample's decrement.
            if (sad_sat <= threshold_V && hold_q == '0) begin
              trig_d = 1'b1;
              hold_d = holdoff_V;
            end
          end else begin
            fill_d = fill_q + CNT_ONE;
          end
        end
        if ((stop_q || ap_stop) && (!out_valid_q || fifo.sumout_V_full_n)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      ld_cnt_q    <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      trig_q      <= 1'b0;
      hold_q      <= '0;
      ready_q     <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      ld_cnt_q    <= ld_cnt_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      trig_q      <= trig_d;
      hold_q      <= hold_d;
      ready_q     <= ready_d;
      stop_q      <= stop_d;
    end
  end

  // Pure datapath storage; validity is tracked by fill_q and n_q, so no reset is needed here.
  always_ff @(posedge ap_clk) begin
    if (ref_we) begin
      for (int j = 0; j < MAX_POINTS; j++) begin
        if (ref_waddr == CNT_WIDTH'(j)) ref_q[j] <= $signed(fifo.ref_points_in_V_dout);
      end
    end
    if (data_rd) begin
      for (int j = 0; j < MAX_POINTS; j++) begin
        win_q[j] <= win_d[j];
      end
    end
  end

  assign fifo.ref_points_in_V_read = ref_rd;
  assign fifo.datain_V_read        = data_rd;
  assign fifo.sumout_V_din         = sum_q;
  assign fifo.sumout_V_write       = out_valid_q && fifo.sumout_V_full_n;
  assign trig_out                  = trig_q;
  assign ap_ready                  = ready_q;
  assign ap_done                   = (state_q == S_DONE);
  assign ap_idle                   = (state_q == S_IDLE);

endmodule

// File: tb/tb_sad_trigger_stream.sv
// Directed bench for sad_trigger_stream: a default-sized instance plus a narrow-sum instance for
// saturation, driven through behavioural FWFT FIFOs with one summary line at the end.
module tb_sad_trigger_stream;
  localparam int DW = 10;
  localparam int SW = 20;
  localparam int CW = 8;
  localparam int HW = 16;

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic ap_rst, ap_start, ap_stop, sel;
  logic start_a, stop_a, start_b, stop_b;
  logic done_a, idle_a, ready_a, trig_a;
  logic done_b, idle_b, ready_b, trig_b;
  logic [CW-1:0] max_a;
  logic [2:0]    max_b;
  logic [SW-1:0] thr_a;
  logic [7:0]    thr_b;
  logic [HW-1:0] hold_a, hold_b;

  assign start_a = ap_start & ~sel;
  assign stop_a  = ap_stop  & ~sel;
  assign start_b = ap_start &  sel;
  assign stop_b  = ap_stop  &  sel;

  sad_trigger_stream_if #(.DATA_WIDTH(DW), .SUM_WIDTH(SW)) if_a ();
  sad_trigger_stream_if #(.DATA_WIDTH(DW), .SUM_WIDTH(8))  if_b ();

  sad_trigger_stream #(.DATA_WIDTH(DW), .MAX_POINTS(128), .CNT_WIDTH(CW), .SUM_WIDTH(SW), .HOLD_WIDTH(HW)) u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(start_a), .ap_stop(stop_a),
    .ap_done(done_a), .ap_idle(idle_a), .ap_ready(ready_a),
    .max_points_V(max_a), .threshold_V(thr_a), .holdoff_V(hold_a),
    .fifo(if_a), .trig_out(trig_a));

  sad_trigger_stream #(.DATA_WIDTH(DW), .MAX_POINTS(4), .CNT_WIDTH(3), .SUM_WIDTH(8), .HOLD_WIDTH(HW)) u_sat (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(start_b), .ap_stop(stop_b),
    .ap_done(done_b), .ap_idle(idle_b), .ap_ready(ready_b),
    .max_points_V(max_b), .threshold_V(thr_b), .holdoff_V(hold_b),
    .fifo(if_b), .trig_out(trig_b));

  int n_checks = 0;
  int n_fail   = 0;
  int rq[$], dq[$], outq[$], trigq[$];
  int ref_reads, data_reads, ready_cnt, done_cnt, trig_cnt, bp_reads;
  int cyc, bp_start, bp_len, first_wr_reads, quiet, last_idle;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_list(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      chk($sformatf("%s[%0d]", tag, k), (k < got.size()) ? got[k] : -1, exp[k]);
    end
  endtask

  task automatic fifo_idle();
    if_a.ref_points_in_V_empty_n = 1'b0; if_a.ref_points_in_V_dout = '0;
    if_a.datain_V_empty_n = 1'b0;        if_a.datain_V_dout = '0;
    if_a.sumout_V_full_n = 1'b1;
    if_b.ref_points_in_V_empty_n = 1'b0; if_b.ref_points_in_V_dout = '0;
    if_b.datain_V_empty_n = 1'b0;        if_b.datain_V_dout = '0;
    if_b.sumout_V_full_n = 1'b1;
  endtask

  task automatic clear_state();
    rq.delete(); dq.delete(); outq.delete(); trigq.delete();
    ref_reads = 0; data_reads = 0; ready_cnt = 0; done_cnt = 0; trig_cnt = 0; bp_reads = 0;
    cyc = 0; bp_start = 0; bp_len = 0; first_wr_reads = -1; quiet = 0; last_idle = 0;
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst = 1'b1; ap_start = 1'b0; ap_stop = 1'b0;
    fifo_idle();
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    clear_state();
  endtask

  // One clock: drive FIFO fronts at the falling edge, observe 1 ns later, commit FIFO pops/pushes.
  task automatic step(input bit start, input bit stop);
    bit full, r_rd, d_rd, wr, trg, rdy, dn, idl;
    int din;
    @(negedge ap_clk);
    ap_start = start;
    ap_stop  = stop;
    full = !(bp_len > 0 && cyc >= bp_start && cyc < bp_start + bp_len);
    fifo_idle();
    if (!sel) begin
      if_a.ref_points_in_V_empty_n = (rq.size() > 0);
      if_a.ref_points_in_V_dout    = (rq.size() > 0) ? DW'(rq[0]) : '0;
      if_a.datain_V_empty_n        = (dq.size() > 0);
      if_a.datain_V_dout           = (dq.size() > 0) ? DW'(dq[0]) : '0;
      if_a.sumout_V_full_n         = full;
    end else begin
      if_b.ref_points_in_V_empty_n = (rq.size() > 0);
      if_b.ref_points_in_V_dout    = (rq.size() > 0) ? DW'(rq[0]) : '0;
      if_b.datain_V_empty_n        = (dq.size() > 0);
      if_b.datain_V_dout           = (dq.size() > 0) ? DW'(dq[0]) : '0;
      if_b.sumout_V_full_n         = full;
    end
    #1;
    r_rd = sel ? if_b.ref_points_in_V_read : if_a.ref_points_in_V_read;
    d_rd = sel ? if_b.datain_V_read        : if_a.datain_V_read;
    wr   = sel ? if_b.sumout_V_write       : if_a.sumout_V_write;
    din  = sel ? int'(if_b.sumout_V_din)   : int'(if_a.sumout_V_din);
    trg  = sel ? trig_b  : trig_a;
    rdy  = sel ? ready_b : ready_a;
    dn   = sel ? done_b  : done_a;
    idl  = sel ? idle_b  : idle_a;
    if (wr) begin
      if (first_wr_reads < 0) first_wr_reads = data_reads;
      outq.push_back(din);
      trigq.push_back(int'(trg));
    end
    if (r_rd) begin
      if (rq.size() > 0) void'(rq.pop_front());
      ref_reads++;
    end
    if (d_rd) begin
      if (dq.size() > 0) void'(dq.pop_front());
      data_reads++;
      if (!full) bp_reads++;
    end
    if (trg) trig_cnt++;
    if (rdy) ready_cnt++;
    if (dn)  done_cnt++;
    last_idle = int'(idl);
    quiet = (r_rd || d_rd || wr) ? 0 : quiet + 1;
    cyc++;
  endtask

  // Start, stream until the sample FIFO is drained and the engine goes quiet, then stop.
  task automatic run(input int n_pts, input int thr, input int hold);
    bit ok;
    ok = 1'b0;
    max_a = CW'(n_pts); max_b = 3'(n_pts);
    thr_a = SW'(thr);   thr_b = 8'(thr);
    hold_a = HW'(hold); hold_b = HW'(hold);
    step(1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'b0);
      if ((ready_cnt > 0 || done_cnt > 0) && dq.size() == 0 && quiet >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    chk("settle_in_budget", int'(ok), 1);
    if (done_cnt == 0) begin
      step(1'b0, 1'b1);
      for (int i = 0; i < 10 && done_cnt == 0; i++) step(1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
  endtask

  initial begin
    sel = 1'b0; ap_rst = 1'b0; ap_start = 1'b0; ap_stop = 1'b0;
    max_a = '0; max_b = '0; thr_a = '0; thr_b = '0; hold_a = '0; hold_b = '0;
    fifo_idle();
    clear_state();

    // Reset state
    do_reset();
    #1;
    chk("rst_idle",     int'(idle_a), 1);
    chk("rst_done",     int'(done_a), 0);
    chk("rst_ready",    int'(ready_a), 0);
    chk("rst_trig",     int'(trig_a), 0);
    chk("rst_ref_read", int'(if_a.ref_points_in_V_read), 0);
    chk("rst_dat_read", int'(if_a.datain_V_read), 0);
    chk("rst_write",    int'(if_a.sumout_V_write), 0);

    // T1: zero reference, N=4
    do_reset();
    rq = '{0, 0, 0, 0};
    dq = '{1, -2, 3, 4, 5};
    run(4, 0, 0);
    chk_list("t1_sum", outq, '{10, 14});
    chk("t1_reads_before_first_write", first_wr_reads, 4);
    chk("t1_ref_reads", ref_reads, 4);
    chk("t1_ready_pulses", ready_cnt, 1);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_idle_after", last_idle, 1);

    // T2a: threshold 0, no holdoff
    do_reset();
    rq = '{10, -10, 0};
    dq = '{10, -10, 0, 10};
    run(3, 0, 0);
    chk_list("t2a_sum", outq, '{0, 40});
    chk_list("t2a_trig", trigq, '{1, 0});
    chk("t2a_trig_total", trig_cnt, 1);

    // T2b: holdoff 5, stream repeats the reference
    do_reset();
    rq = '{10, -10, 0};
    dq = '{10, -10, 0, 10, -10, 0, 10, -10, 0};
    run(3, 0, 5);
    chk_list("t2b_sum", outq, '{0, 40, 40, 0, 40, 40, 0});
    chk_list("t2b_trig", trigq, '{1, 0, 0, 0, 0, 0, 1});
    chk("t2b_trig_total", trig_cnt, 2);

    // T3: output backpressure for 6 cycles mid-stream
    do_reset();
    rq = '{1, 2, 3};
    dq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    bp_start = 9; bp_len = 6;
    run(3, 0, 0);
    chk_list("t3_sum", outq, '{3, 0, 3, 6, 9, 12, 15, 18, 21, 24});
    chk("t3_reads_while_full", bp_reads, 0);
    chk("t3_trig_total", trig_cnt, 1);

    // T4a: N above MAX_POINTS is clamped
    do_reset();
    for (int k = 0; k < 130; k++) rq.push_back(k - 60);
    run(200, 0, 0);
    chk("t4a_ref_reads", ref_reads, 128);
    chk("t4a_ref_left", rq.size(), 2);
    chk("t4a_ready_pulses", ready_cnt, 1);
    chk("t4a_done_pulses", done_cnt, 1);

    // T4b: N=0 finishes without touching the FIFOs
    do_reset();
    rq = '{1, 2};
    run(0, 0, 0);
    chk("t4b_ref_reads", ref_reads, 0);
    chk("t4b_ready_pulses", ready_cnt, 0);
    chk("t4b_done_pulses", done_cnt, 1);
    chk("t4b_idle_after", last_idle, 1);

    // T5: 8-bit saturating sums on the narrow instance
    sel = 1'b1;
    do_reset();
    rq = '{-512, -512, -512, -512};
    dq = '{511, 511, 511, 511, 511};
    run(4, 0, 0);
    chk_list("t5_sum", outq, '{255, 255});
    chk("t5_done_pulses", done_cnt, 1);
    sel = 1'b0;

    // T6: reset in the middle of RUN, then restart with N=2
    do_reset();
    rq = '{0, 0, 0, 0};
    dq = '{7, 7, 7, 7, 7, 7};
    max_a = CW'(4);
    step(1'b1, 1'b0);
    for (int i = 0; i < 40 && data_reads < 2; i++) step(1'b0, 1'b0);
    chk("t6_reached_run", data_reads, 2);
    do_reset();
    #1;
    chk("t6_idle_after_rst", int'(idle_a), 1);
    chk("t6_write_after_rst", int'(if_a.sumout_V_write), 0);
    rq = '{5, -5};
    dq = '{1, 2, -3};
    run(2, 0, 0);
    chk_list("t6_sum", outq, '{11, 5});
    chk("t6_reads_before_first_write", first_wr_reads, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
